// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core. An FSM sequences the datapath, and instruction fetch and
// lw/sw data accesses share one registered req/ack memory port.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_AW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       pc,
  output logic              retire,
  output logic              halted
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, RWB, IWB, LWB, HALT} stateT;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  stateT       state, nextState;
  logic [31:0] ir, regA, regB, aluOut, mdr;
  logic [31:0] regFile [32];

  logic [31:0] pcNext, irNext, aNext, bNext, aluNext, mdrNext;
  logic        retireNext;
  logic        wrEn;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic        illegal;
  logic [31:0] rAlu;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] immExt, jumpTarget, rsVal, rtVal;

  logic        reqBusy, issueReq, reqWe;
  logic [31:0] reqAddr, reqWdata;

  assign opcode     = ir[31:26];
  assign rs         = ir[25:21];
  assign rt         = ir[20:16];
  assign rd         = ir[15:11];
  assign funct      = ir[5:0];
  assign immExt     = {{16{ir[15]}}, ir[15:0]};
  assign jumpTarget = {pc[31:28], ir[25:0], 2'b00};
  assign rsVal      = (rs == 5'd0) ? 32'd0 : regFile[rs];
  assign rtVal      = (rt == 5'd0) ? 32'd0 : regFile[rt];

  always_comb begin
    case (opcode)
      OP_RTYPE: illegal = !(funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_JR});
      OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL: illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (funct)
      FN_ADD:  rAlu = regA + regB;
      FN_SUB:  rAlu = regA - regB;
      FN_AND:  rAlu = regA & regB;
      FN_OR:   rAlu = regA | regB;
      FN_SLT:  rAlu = {31'd0, $signed(regA) < $signed(regB)};
      default: rAlu = '0;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    nextState  = state;
    pcNext     = pc;
    irNext     = ir;
    aNext      = regA;
    bNext      = regB;
    aluNext    = aluOut;
    mdrNext    = mdr;
    retireNext = 1'b0;
    wrEn       = 1'b0;
    wrAddr     = '0;
    wrData     = '0;
    unique case (state)
      FETCH: begin
        if (mem_req && mem_ack) begin
          irNext    = mem_rdata;
          pcNext    = pc + 32'd4;
          nextState = DECODE;
        end
      end
      DECODE: begin
        aNext   = rsVal;
        bNext   = rtVal;
        aluNext = pc + (immExt << 2);
        if (illegal) begin
          nextState = HALT;
        end else if (opcode == OP_J || opcode == OP_JAL) begin
          pcNext     = jumpTarget;
          retireNext = 1'b1;
          nextState  = FETCH;
          if (opcode == OP_JAL) begin
            wrEn   = 1'b1;
            wrAddr = 5'd31;
            wrData = pc;
          end
        end else begin
          nextState = EXEC;
        end
      end
      EXEC: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_JR) begin
              pcNext     = regA;
              retireNext = 1'b1;
              nextState  = FETCH;
            end else begin
              aluNext   = rAlu;
              nextState = RWB;
            end
          end
          OP_ADDI: begin
            aluNext   = regA + immExt;
            nextState = IWB;
          end
          OP_SLTI: begin
            aluNext   = {31'd0, $signed(regA) < $signed(immExt)};
            nextState = IWB;
          end
          OP_LW, OP_SW: begin
            aluNext   = regA + immExt;
            nextState = MEM;
          end
          OP_BEQ: begin
            if (regA == regB) pcNext = aluOut;
            retireNext = 1'b1;
            nextState  = FETCH;
          end
          default: nextState = HALT;
        endcase
      end
      MEM: begin
        if (mem_req && mem_ack) begin
          if (opcode == OP_SW) begin
            retireNext = 1'b1;
            nextState  = FETCH;
          end else begin
            mdrNext   = mem_rdata;
            nextState = LWB;
          end
        end
      end
      RWB, IWB, LWB: begin
        wrEn       = 1'b1;
        wrAddr     = (state == RWB) ? rd : rt;
        wrData     = (state == LWB) ? mdr : aluOut;
        retireNext = 1'b1;
        nextState  = FETCH;
      end
      HALT: nextState = HALT;
      default: nextState = HALT;
    endcase
  end

  // A new access is launched on entry to FETCH/MEM; the only FETCH without a pending
  // request is the first cycle after reset, which launches the fetch at pc.
  assign reqBusy  = mem_req && !mem_ack;
  assign issueReq = !reqBusy && (nextState == FETCH || nextState == MEM);
  assign reqAddr  = (nextState == MEM) ? aluNext : pcNext;
  assign reqWe    = (nextState == MEM) && (opcode == OP_SW);
  assign reqWdata = reqWe ? regB : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      regA      <= '0;
      regB      <= '0;
      aluOut    <= '0;
      mdr       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      retire    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state  <= nextState;
      pc     <= pcNext;
      ir     <= irNext;
      regA   <= aNext;
      regB   <= bNext;
      aluOut <= aluNext;
      mdr    <= mdrNext;
      retire <= retireNext;
      if (nextState == HALT) halted <= 1'b1;
      if (issueReq) begin
        mem_req   <= 1'b1;
        mem_we    <= reqWe;
        mem_addr  <= reqAddr[MEM_AW-1:0];
        mem_wdata <= reqWdata;
      end else if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
    end
  end

  // NOTE: the register file is cleared on reset, so it stays in flops rather than RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
    end else if (wrEn && wrAddr != 5'd0) begin
      regFile[wrAddr] <= wrData;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench: per-test program tables feed retire and store scoreboards,
// served by a memory model with configurable wait states.
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] pc;
  logic        retire, halted;

  always #5 clk = ~clk;

  mips_multicycle_core #(.RESET_PC(32'h0000_0000), .MEM_AW(32)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc(pc), .retire(retire), .halted(halted)
  );

  localparam logic [5:0] OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010, FN_JR = 6'b001000;

  typedef struct { logic [31:0] addr; logic [31:0] instr; logic [31:0] expPc; int lat; } vecT;
  typedef struct { logic [31:0] addr; logic [31:0] data; } storeT;
  typedef struct { logic [31:0] expPc; int lat; } retT;

  logic [31:0] mem [0:255];
  vecT   progQ[$];
  storeT stQ[$];
  retT   retireQ[$];
  storeT storeQ[$];
  int    retireAt[$];

  int vectors = 0, miscompares = 0;
  int cycle = 0, mark = 0, firstMark = 0;
  bit waitingFirst = 1'b1;
  int waitStates = 0, waitCnt = 0;
  logic [31:0] capAddr, capWdata;
  logic        capWe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] encR(input logic [5:0] fn, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] encJ(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

  task automatic addVec(input logic [31:0] addr, input logic [31:0] instr,
                        input logic [31:0] expPc, input int lat);
    progQ.push_back('{addr, instr, expPc, lat});
  endtask

  task automatic addStore(input logic [31:0] addr, input logic [31:0] data);
    stQ.push_back('{addr, data});
  endtask

  always @(posedge clk) cycle++;

  // Memory model: inputs change on the falling edge, away from the DUT's sampling edge.
  always @(negedge clk) begin
    storeT s;
    if (mem_ack || !mem_req) waitCnt = 0;
    mem_ack = 1'b0;
    if (mem_req) begin
      if (waitCnt == 0) begin
        capAddr  = mem_addr;
        capWe    = mem_we;
        capWdata = mem_wdata;
      end else begin
        check("req_stable_addr", mem_addr, capAddr);
        check("req_stable_we", {31'd0, mem_we}, {31'd0, capWe});
        check("req_stable_wdata", mem_wdata, capWdata);
      end
      if (waitCnt >= waitStates) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr[9:2]];
        if (mem_we) begin
          mem[mem_addr[9:2]] = mem_wdata;
          if (storeQ.size() == 0) begin
            check("unexpected_store", mem_addr, 32'hFFFF_FFFF);
          end else begin
            s = storeQ.pop_front();
            check("store_addr", mem_addr, s.addr);
            check("store_data", mem_wdata, s.data);
          end
        end
      end else begin
        waitCnt++;
      end
    end
  end

  // Retire scoreboard: pc after retire and cycles since the previous retire (or first request).
  always @(negedge clk) begin
    retT e;
    if (waitingFirst && mem_req) begin
      mark         = cycle;
      firstMark    = cycle;
      waitingFirst = 1'b0;
    end
    if (retire) begin
      if (retireQ.size() == 0) begin
        check("unexpected_retire", pc, 32'hFFFF_FFFF);
      end else begin
        e = retireQ.pop_front();
        check("retire_pc", pc, e.expPc);
        check("retire_lat", 32'(cycle - mark), 32'(e.lat));
      end
      mark = cycle;
      retireAt.push_back(cycle);
    end
  end

  task automatic loadAndStart();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    foreach (progQ[i]) mem[progQ[i].addr[9:2]] = progQ[i].instr;
    @(posedge clk); #1;
    rst = 1'b0;
    retireQ.delete();
    storeQ.delete();
    retireAt.delete();
    waitingFirst = 1'b1;
    foreach (progQ[i]) retireQ.push_back('{progQ[i].expPc, progQ[i].lat});
    foreach (stQ[i]) storeQ.push_back(stQ[i]);
    progQ.delete();
    stQ.delete();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_pc", pc, 32'h0000_0000);
    check("rst_retire", {31'd0, retire}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && retireQ.size() != 0; i++) @(posedge clk);
    check("retires_pending", 32'(retireQ.size()), 32'd0);
    check("stores_pending", 32'(storeQ.size()), 32'd0);
  endtask

  initial begin
    bit found;
    bit sawReq;
    repeat (2) @(posedge clk);

    // Zero-wait ALU program, results observed through stores.
    waitStates = 0;
    addVec(32'h00, encI(OP_ADDI, 5'd1, 5'd0, 16'd5),      32'h04, 4);
    addVec(32'h04, encI(OP_ADDI, 5'd2, 5'd0, 16'hFFFD),   32'h08, 4);
    addVec(32'h08, encR(FN_ADD, 5'd3, 5'd1, 5'd2),        32'h0C, 4);
    addVec(32'h0C, encR(FN_SLT, 5'd4, 5'd2, 5'd1),        32'h10, 4);
    addVec(32'h10, encR(FN_SUB, 5'd6, 5'd1, 5'd2),        32'h14, 4);
    addVec(32'h14, encR(FN_AND, 5'd7, 5'd1, 5'd2),        32'h18, 4);
    addVec(32'h18, encR(FN_OR,  5'd8, 5'd1, 5'd2),        32'h1C, 4);
    addVec(32'h1C, encI(OP_SLTI, 5'd9, 5'd2, 16'hFFFE),   32'h20, 4);
    addVec(32'h20, encI(OP_SW, 5'd3, 5'd0, 16'h80),       32'h24, 4);
    addVec(32'h24, encI(OP_SW, 5'd4, 5'd0, 16'h84),       32'h28, 4);
    addVec(32'h28, encI(OP_SW, 5'd6, 5'd0, 16'h88),       32'h2C, 4);
    addVec(32'h2C, encI(OP_SW, 5'd7, 5'd0, 16'h8C),       32'h30, 4);
    addVec(32'h30, encI(OP_SW, 5'd8, 5'd0, 16'h90),       32'h34, 4);
    addVec(32'h34, encI(OP_SW, 5'd9, 5'd0, 16'h94),       32'h38, 4);
    addStore(32'h80, 32'd2);          // 5 + -3
    addStore(32'h84, 32'd1);          // -3 < 5
    addStore(32'h88, 32'd8);          // 5 - -3
    addStore(32'h8C, 32'd5);          // 5 & 0xFFFFFFFD
    addStore(32'h90, 32'hFFFF_FFFD);  // 5 | 0xFFFFFFFD
    addStore(32'h94, 32'd1);          // -3 < -2
    loadAndStart();
    waitDrain(400);
    if (retireAt.size() >= 4) check("four_instr_cycles", 32'(retireAt[3] - firstMark), 32'd16);
    else check("four_instr_retires", 32'(retireAt.size()), 32'd4);

    // Three wait states on every access: sw/lw round trip.
    waitStates = 3;
    addVec(32'h00, encJ(OP_J, 26'h10),                    32'h40, 5);
    addVec(32'h40, encI(OP_ADDI, 5'd3, 5'd0, 16'd2),      32'h44, 7);
    addVec(32'h44, encI(OP_SW, 5'd3, 5'd0, 16'h8),        32'h48, 10);
    addVec(32'h48, encI(OP_LW, 5'd5, 5'd0, 16'h8),        32'h4C, 11);
    addVec(32'h4C, encI(OP_SW, 5'd5, 5'd0, 16'h80),       32'h50, 10);
    addStore(32'h08, 32'd2);
    addStore(32'h80, 32'd2);
    loadAndStart();
    waitDrain(600);

    // r0 write discarded, beq not taken then taken back onto itself.
    waitStates = 0;
    addVec(32'h00, encI(OP_ADDI, 5'd0, 5'd0, 16'd7),      32'h04, 4);
    addVec(32'h04, encI(OP_ADDI, 5'd1, 5'd0, 16'd1),      32'h08, 4);
    addVec(32'h08, encI(OP_SW, 5'd0, 5'd0, 16'h80),       32'h0C, 4);
    addVec(32'h0C, encI(OP_BEQ, 5'd2, 5'd1, 16'd4),       32'h10, 3);
    for (int i = 0; i < 3; i++)
      addVec(32'h10, encI(OP_BEQ, 5'd1, 5'd1, 16'hFFFF),  32'h10, 3);
    addStore(32'h80, 32'd0);
    loadAndStart();
    waitDrain(400);

    // j / jal / jr, then an illegal opcode halts the core.
    addVec(32'h000, encJ(OP_J, 26'h8),                    32'h020, 2);
    addVec(32'h020, encJ(OP_JAL, 26'h40),                 32'h100, 2);
    addVec(32'h100, encI(OP_SW, 5'd31, 5'd0, 16'h80),     32'h104, 4);
    addVec(32'h104, encR(FN_JR, 5'd0, 5'd31, 5'd0),       32'h024, 3);
    addVec(32'h024, {6'b111111, 26'd0},                   32'h024, 0);
    void'(progQ.pop_back());
    mem[9] = '0;
    loadAndStart();
    mem[9] = {6'b111111, 26'd0};
    addStore(32'h80, 32'h24);
    storeQ.push_back(stQ.pop_front());
    waitDrain(400);
    sawReq = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req) sawReq = 1'b1;
    end
    check("halt_no_req", {31'd0, sawReq}, 32'd0);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_pc", pc, 32'h28);

    // Reset while an lw is stalled in MEM.
    waitStates = 50;
    addVec(32'h00, encI(OP_ADDI, 5'd5, 5'd0, 16'd9),      32'h04, 54);
    loadAndStart();
    mem[1]  = encI(OP_LW, 5'd5, 5'd0, 16'h80);
    mem[32] = 32'h0000_1234;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == 32'h80) found = 1'b1;
    end
    check("lw_reached_mem", {31'd0, found}, 32'd1);
    repeat (5) @(negedge clk);
    waitStates = 0;
    addVec(32'h00, encI(OP_SW, 5'd5, 5'd0, 16'h84),       32'h04, 4);
    addStore(32'h84, 32'd0);
    loadAndStart();
    waitDrain(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog");
  end

endmodule
